// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue: slot 0 holds the oldest entry.
// Entries wake up on CDB tag matches; the oldest fully ready entry is issued.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       enq,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [TAG_W-1:0]           src1_tag,
  input  logic [TAG_W-1:0]           src2_tag,
  input  logic                       src1_rdy,
  input  logic                       src2_rdy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [DATA_W-1:0]          issue_data
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic              v;
    logic              r1;
    logic              r2;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          woke  [DEPTH+1];
  ent_t          new_ent;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic [DEPTH-1:0] rdy_vec;
  logic [IW-1:0] sel_idx;
  logic          fire;
  logic          do_enq;

  assign count  = count_q;
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign fire   = issue_valid & issue_ready;
  assign do_enq = enq & ~full;
  assign wr_idx = count_q - CW'(fire);

  // Readiness uses registered bits only; wakeups land in the next-state copy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].v & ent_q[i].r1 & ent_q[i].r2;
      woke[i]    = ent_q[i];
      if (cdb_valid && ent_q[i].v) begin
        if (ent_q[i].t1 == cdb_tag) woke[i].r1 = 1'b1;
        if (ent_q[i].t2 == cdb_tag) woke[i].r2 = 1'b1;
      end
    end
    woke[DEPTH] = '0;
  end

  always_comb begin
    sel_idx     = '0;
    issue_valid = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        sel_idx     = IW'(i);
        issue_valid = 1'b1;
      end
    end
  end

  assign issue_data = issue_valid ? ent_q[sel_idx].d : '0;

  always_comb begin
    new_ent    = '0;
    new_ent.v  = 1'b1;
    new_ent.r1 = src1_rdy | (cdb_valid && (src1_tag == cdb_tag));
    new_ent.r2 = src2_rdy | (cdb_valid && (src2_tag == cdb_tag));
    new_ent.t1 = src1_tag;
    new_ent.t2 = src2_tag;
    new_ent.d  = data_i;
  end

  // Entries at or above the issued slot take their younger neighbour's state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (fire && (IW'(i) >= sel_idx)) ? woke[i+1] : woke[i];
      if (do_enq && (CW'(i) == wr_idx)) ent_d[i] = new_ent;
    end
  end

  always_comb begin
    case ({do_enq, fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].v  <= 1'b0;
        ent_q[i].r1 <= 1'b0;
        ent_q[i].r2 <= 1'b0;
      end
    end else if (flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].v <= 1'b0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: queue-based reference model feeding a scoreboard
// that a negedge monitor drains and compares against the DUT outputs.
module tb_issue_queue;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              enq;
  logic [DATA_W-1:0] data_i;
  logic [TAG_W-1:0]  src1_tag, src2_tag;
  logic              src1_rdy, src2_rdy;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_data;

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .enq(enq), .data_i(data_i),
    .src1_tag(src1_tag), .src2_tag(src2_tag), .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
    .full(full), .empty(empty), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    bit                r1;
    bit                r2;
  } m_ent_t;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] id;
    int                cnt;
  } exp_t;

  m_ent_t mq[$];
  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  function automatic void push_expect();
    exp_t e;
    int s;
    s     = m_sel();
    e.iv  = (s >= 0);
    e.id  = (s >= 0) ? mq[s].d : '0;
    e.cnt = mq.size();
    exp_q.push_back(e);
  endfunction

  function automatic void m_step(bit e, logic [DATA_W-1:0] d, logic [TAG_W-1:0] t1, bit r1,
                                 logic [TAG_W-1:0] t2, bit r2, bit cv, logic [TAG_W-1:0] ct,
                                 bit ir, bit fl);
    int     s;
    bit     was_full;
    m_ent_t n;
    m_ent_t tmp;
    if (fl) begin
      mq.delete();
      return;
    end
    s        = m_sel();
    was_full = (mq.size() == DEPTH);
    if (cv) begin
      for (int i = 0; i < mq.size(); i++) begin
        tmp = mq[i];
        if (tmp.t1 == ct) tmp.r1 = 1'b1;
        if (tmp.t2 == ct) tmp.r2 = 1'b1;
        mq[i] = tmp;
      end
    end
    if (s >= 0 && ir) mq.delete(s);
    if (e && !was_full) begin
      n.d  = d;
      n.t1 = t1;
      n.t2 = t2;
      n.r1 = r1 || (cv && t1 == ct);
      n.r2 = r2 || (cv && t2 == ct);
      mq.push_back(n);
    end
  endfunction

  task automatic drive_idle();
    enq = 0; data_i = '0; src1_tag = '0; src2_tag = '0; src1_rdy = 1; src2_rdy = 1;
    cdb_valid = 0; cdb_tag = '0; issue_ready = 0; flush = 0;
  endtask

  task automatic cycle(input bit e, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t1,
                       input bit r1, input logic [TAG_W-1:0] t2, input bit r2, input bit cv,
                       input logic [TAG_W-1:0] ct, input bit ir, input bit fl);
    @(posedge clk);
    #1;
    push_expect();
    enq = e; data_i = d; src1_tag = t1; src1_rdy = r1; src2_tag = t2; src2_rdy = r2;
    cdb_valid = cv; cdb_tag = ct; issue_ready = ir; flush = fl;
    m_step(e, d, t1, r1, t2, r2, cv, ct, ir, fl);
  endtask

  task automatic idle(input bit ir);
    cycle(0, '0, '0, 1, '0, 1, 0, '0, ir, 0);
  endtask

  task automatic enq_rdy(input logic [DATA_W-1:0] d, input bit ir);
    cycle(1, d, 6'd1, 1, 6'd2, 1, 0, '0, ir, 0);
  endtask

  // Reset asserted mid-cycle and held across the negedge sample.
  task automatic rst_pulse();
    @(posedge clk);
    #1;
    resetn = 0;
    drive_idle();
    mq.delete();
    push_expect();
    #5;
    resetn = 1;
  endtask

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_valid", {31'b0, issue_valid}, {31'b0, e.iv});
        chk("issue_data", issue_data, e.id);
        chk("count", DATA_W'(count), DATA_W'(e.cnt));
        chk("full", {31'b0, full}, {31'b0, e.cnt == DEPTH});
        chk("empty", {31'b0, empty}, {31'b0, e.cnt == 0});
      end
    end
  end

  initial begin : driver
    resetn = 0;
    drive_idle();
    push_expect();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1;

    // single ready op issues the cycle after enqueue
    enq_rdy(32'hA, 0);
    idle(1);
    idle(0);

    // wakeup through src1 tag 5
    cycle(1, 32'hB, 6'd5, 0, 6'd0, 1, 0, '0, 0, 0);
    cycle(0, '0, '0, 1, '0, 1, 1, 6'd5, 0, 0);
    idle(1);
    idle(0);

    // fill, then enqueue while full with an issue firing
    for (int i = 0; i < DEPTH; i++) enq_rdy(32'h100 + i, 0);
    enq_rdy(32'h1FF, 1);
    idle(0);
    for (int i = 0; i < DEPTH; i++) idle(1);

    // oldest not ready: younger ready ones bypass it
    cycle(1, 32'hC, 6'd20, 0, 6'd0, 1, 0, '0, 1, 0);
    enq_rdy(32'hD, 1);
    enq_rdy(32'hE, 1);
    idle(1);
    idle(1);
    idle(1);
    cycle(0, '0, '0, 1, '0, 1, 1, 6'd20, 0, 0);
    idle(1);
    idle(0);

    // enqueue coinciding with matching broadcast on src2
    cycle(1, 32'h35, 6'd3, 1, 6'd9, 0, 1, 6'd9, 0, 0);
    idle(1);
    idle(0);

    // flush beats enqueue and issue
    for (int i = 0; i < 3; i++) enq_rdy(32'h200 + i, 0);
    cycle(1, 32'h2FF, 6'd1, 1, 6'd2, 1, 0, '0, 1, 1);
    idle(0);

    // reset mid-fill, then normal operation resumes
    for (int i = 0; i < 3; i++) enq_rdy(32'h300 + i, 0);
    rst_pulse();
    idle(0);
    enq_rdy(32'h3AA, 0);
    idle(1);
    idle(0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) rst_pulse();
      else cycle($urandom_range(0, 9) < 7, $urandom,
                 TAG_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 TAG_W'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
    end
    idle(0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
